// File: rtl/multicycle_control_pkg.sv
// +--------------------------------------------------------------------------+
// | multicycle_control_pkg                                                   |
// | Shared encodings for the multi-cycle RV32 control path.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package multicycle_control_pkg;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADR   = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      ALU_WB    = 4'd7,
      BEQ       = 4'd8,
      TRAP      = 4'd9
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   // Shared with the downstream ALU control decoder.
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic       ADR_PC     = 1'b0;
   localparam logic       ADR_ALUOUT = 1'b1;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
// +--------------------------------------------------------------------------+
// | multicycle_control_if                                                    |
// | Control-to-datapath bundle: status inputs, enables and mux selects.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface multicycle_control_if;
   logic [6:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       ir_write;
   logic       adr_src;
   logic       mem_write;
   logic       reg_write;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] result_src;
   logic [1:0] alu_operation;
   logic       instr_retired;
   logic       trap;

   modport slave (
      input  opcode, zero, mem_ready,
      output pc_write, ir_write, adr_src, mem_write, reg_write,
             alu_src_a, alu_src_b, result_src, alu_operation,
             instr_retired, trap
   );

   modport master (
      output opcode, zero, mem_ready,
      input  pc_write, ir_write, adr_src, mem_write, reg_write,
             alu_src_a, alu_src_b, result_src, alu_operation,
             instr_retired, trap
   );
endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
// +--------------------------------------------------------------------------+
// | multicycle_control                                                       |
// | Moore control FSM sequencing lw/sw/R-type/beq on the multi-cycle RV32.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module multicycle_control
   import multicycle_control_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   multicycle_control_if.slave     bus
);

   state_t     r_state;
   state_t     w_next;

   logic       w_pc_write;
   logic       w_ir_write;
   logic       w_adr_src;
   logic       w_mem_write;
   logic       w_reg_write;
   logic [1:0] w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_result_src;
   logic [1:0] w_alu_operation;
   logic       w_instr_retired;
   logic       w_trap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= FETCH;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         FETCH:     w_next = bus.mem_ready ? DECODE : FETCH;
         DECODE: begin
            case (bus.opcode)
               OP_LW, OP_SW: w_next = MEM_ADR;
               OP_R:         w_next = EXEC_R;
               OP_BEQ:       w_next = BEQ;
               default:      w_next = TRAP;
            endcase
         end
         MEM_ADR:   w_next = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
         MEM_READ:  w_next = bus.mem_ready ? MEM_WB : MEM_READ;
         MEM_WB:    w_next = FETCH;
         MEM_WRITE: w_next = bus.mem_ready ? FETCH : MEM_WRITE;
         EXEC_R:    w_next = ALU_WB;
         ALU_WB:    w_next = FETCH;
         BEQ:       w_next = FETCH;
         TRAP:      w_next = TRAP;
         default:   w_next = TRAP;
      endcase
   end

   always_comb begin
      w_pc_write      = 1'b0;
      w_ir_write      = 1'b0;
      w_adr_src       = ADR_PC;
      w_mem_write     = 1'b0;
      w_reg_write     = 1'b0;
      w_alu_src_a     = SRCA_PC;
      w_alu_src_b     = SRCB_RS2;
      w_result_src    = RES_ALUOUT;
      w_alu_operation = ALUOP_ADD;
      w_instr_retired = 1'b0;
      w_trap          = 1'b0;
      case (r_state)
         FETCH: begin
            w_alu_src_b  = SRCB_FOUR;
            w_result_src = RES_ALU;
            w_ir_write   = bus.mem_ready;
            w_pc_write   = bus.mem_ready;
         end
         DECODE: begin
            w_alu_src_a = SRCA_OLDPC;
            w_alu_src_b = SRCB_IMM;
         end
         MEM_ADR: begin
            w_alu_src_a = SRCA_RS1;
            w_alu_src_b = SRCB_IMM;
         end
         MEM_READ:  w_adr_src = ADR_ALUOUT;
         MEM_WB: begin
            w_result_src    = RES_DATA;
            w_reg_write     = 1'b1;
            w_instr_retired = 1'b1;
         end
         MEM_WRITE: begin
            w_adr_src       = ADR_ALUOUT;
            w_mem_write     = 1'b1;
            w_instr_retired = bus.mem_ready;
         end
         EXEC_R: begin
            w_alu_src_a     = SRCA_RS1;
            w_alu_operation = ALUOP_FUNCT;
         end
         ALU_WB: begin
            w_reg_write     = 1'b1;
            w_instr_retired = 1'b1;
         end
         BEQ: begin
            w_alu_src_a     = SRCA_RS1;
            w_alu_operation = ALUOP_SUB;
            w_pc_write      = bus.zero;
            w_instr_retired = 1'b1;
         end
         TRAP:    w_trap = 1'b1;
         default: w_trap = 1'b1;
      endcase
      // Strobes are gated by reset itself so a held mem_write dies the instant reset rises.
      if (reset) begin
         w_pc_write      = 1'b0;
         w_ir_write      = 1'b0;
         w_mem_write     = 1'b0;
         w_reg_write     = 1'b0;
         w_instr_retired = 1'b0;
      end
   end

   assign bus.pc_write      = w_pc_write;
   assign bus.ir_write      = w_ir_write;
   assign bus.adr_src       = w_adr_src;
   assign bus.mem_write     = w_mem_write;
   assign bus.reg_write     = w_reg_write;
   assign bus.alu_src_a     = w_alu_src_a;
   assign bus.alu_src_b     = w_alu_src_b;
   assign bus.result_src    = w_result_src;
   assign bus.alu_operation = w_alu_operation;
   assign bus.instr_retired = w_instr_retired;
   assign bus.trap          = w_trap;

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multi-cycle RV32 datapath; sits directly upstream of the ALU control decoder and drives its 2-bit `alu_operation` input. Per instruction it sequences fetch, decode, execute, memory and write-back, and emits all datapath enables and mux selects. Supports lw, sw, R-type (add/sub/and/or) and beq. Any other opcode parks the FSM in a trap state.

## Interface
Parameters:
- none (opcode and encoding constants come from the shared package)

Ports:
- `clk` in 1: single clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; forces state to FETCH.
- `opcode` in 7: `instr[6:0]` from the instruction register, valid from DECODE onward.
- `zero` in 1: ALU zero flag, same cycle.
- `mem_ready` in 1: memory handshake; an access completes in the cycle it is high.
- `pc_write` out 1: PC load enable.
- `ir_write` out 1: instruction register and old-PC register load enable.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_write` out 1: memory write strobe.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: 00 = PC, 01 = oldPC, 10 = rs1 data.
- `alu_src_b` out 2: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- `result_src` out 2: 00 = ALUOut, 01 = data register, 10 = ALU result.
- `alu_operation` out 2: 00 = add, 01 = subtract, 10 = decode funct3/funct7.
- `instr_retired` out 1: one-cycle pulse on the last cycle of each instruction.
- `trap` out 1: high while in TRAP.

## Operation
- Moore FSM. All outputs decode combinationally from the registered state, plus `mem_ready`/`zero` where noted.
- Any output not listed for a state is 0.
- FETCH:
  - adr_src=0, alu_src_a=00, alu_src_b=10, alu_operation=00, result_src=10.
  - ir_write = pc_write = mem_ready.
  - Next state: DECODE if mem_ready, else stay in FETCH.
- DECODE:
  - alu_src_a=01, alu_src_b=01, alu_operation=00 (branch target into ALUOut).
  - Next state by opcode:
    - 0000011 or 0100011 → MEM_ADR
    - 0110011 → EXEC_R
    - 1100011 → BEQ
    - any other → TRAP
- MEM_ADR:
  - alu_src_a=10, alu_src_b=01, alu_operation=00.
  - Next state: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ:
  - adr_src=1.
  - Next state: MEM_WB when mem_ready, else stay.
- MEM_WB:
  - result_src=01, reg_write=1, instr_retired=1.
  - Next state: FETCH.
- MEM_WRITE:
  - adr_src=1, mem_write=1 (held until accepted), instr_retired=mem_ready.
  - Next state: FETCH when mem_ready, else stay.
- EXEC_R:
  - alu_src_a=10, alu_src_b=00, alu_operation=10.
  - Next state: ALU_WB.
- ALU_WB:
  - result_src=00, reg_write=1, instr_retired=1.
  - Next state: FETCH.
- BEQ:
  - alu_src_a=10, alu_src_b=00, alu_operation=01, result_src=00.
  - pc_write=zero, instr_retired=1.
  - Next state: FETCH.
- TRAP:
  - trap=1, all strobes 0.
  - Exit only by reset.

## Timing
- Reset values:
  - state = FETCH.
  - While `reset` is high, all strobes are forced to 0: pc_write, ir_write, mem_write, reg_write, instr_retired.
  - trap=0.
  - Selects take their FETCH values.
- Reset mid-instruction aborts immediately. No partial write may occur after reset rises, including a held mem_write.
- Cycles per instruction with mem_ready always high:
  - lw 5, sw 4, R-type 4, beq 3.
  - Each cycle mem_ready is low in FETCH, MEM_READ or MEM_WRITE adds one cycle.
- mem_write stays asserted, with adr_src stable, every cycle until mem_ready is sampled high. It drops on the next edge.
- opcode is sampled only in DECODE and MEM_ADR. Changes in other states have no effect.
- instr_retired pulses exactly once per completed instruction, never in TRAP.

## Structure
- Shared package:
  - State enum: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, ALU_WB, BEQ, TRAP.
  - Opcode constants: OP_LW, OP_SW, OP_R, OP_BEQ.
  - ALU-operation codes: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10.
  - Mux-select constants.
- The ALU control decoder consumes these same ALUOP codes from the package.
- One state register plus a next-state/output decode. No sub-module.

## Test plan
- Reset held 3 cycles, then released, with mem_ready=1 and opcode=0110011:
  - After reset, FETCH asserts ir_write=1 and pc_write=1.
  - State sequence FETCH, DECODE, EXEC_R, ALU_WB.
  - alu_operation=10 in EXEC_R; reg_write=1 and instr_retired=1 in ALU_WB; 4 cycles.
- lw with mem_ready low 2 cycles in MEM_READ:
  - MEM_READ held 3 cycles with adr_src=1.
  - MEM_WB then asserts result_src=01 and reg_write=1; 7 cycles total.
- sw with mem_ready low 1 cycle in MEM_WRITE:
  - mem_write=1 for exactly 2 consecutive cycles; instr_retired only on the second.
- beq with zero=1 → pc_write=1 in BEQ. beq with zero=0 → pc_write=0. Both use alu_operation=01 and take 3 cycles.
- opcode=1111111 → trap=1 from the cycle after DECODE and held 10 cycles with all strobes 0. Reset returns the FSM to FETCH.
- Reset asserted mid-MEM_WRITE while mem_ready=0 → mem_write falls in the same cycle (asynchronous) and state is FETCH on release.
